mavg_filter_mc: RTL

Multi-channel, parametrised moving-average FIR filter. It is the successor to the single-channel 16-bit moving-average filter. Time-multiplexed signed samples for up to CHANNELS independent streams arrive on a valid/ready input. The block keeps a per-channel running sum over a runtime-selectable power-of-two window and emits the windowed average on a valid/ready output. It sits between the sample source (ROM/ADC front end) and downstream scaling/display logic.

---
 rtl/mavg_filter_mc.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mavg_filter_mc.sv
// Multi-channel moving-average filter: per-channel history ring and running sum,
// power-of-two window selected at reset/flush, one-deep registered valid/ready output.
module mavg_filter_mc #(
  parameter int DATA_W         = 16,
  parameter int CHANNELS       = 4,
  parameter int MAX_LOG2_DEPTH = 5,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               win_log2,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]          s_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]          m_chan,
  output logic                     err_chan
);

  localparam int DEPTH = 2 ** MAX_LOG2_DEPTH;
  localparam int PW    = MAX_LOG2_DEPTH;
  localparam int SUM_W = DATA_W + MAX_LOG2_DEPTH;
  localparam logic [2:0]    WIN_MAX = 3'((MAX_LOG2_DEPTH > 7) ? 7 : MAX_LOG2_DEPTH);
  localparam logic [CH_W:0] CH_LIM  = (CH_W + 1)'(CHANNELS);

  logic signed [DATA_W-1:0] ring_q   [CHANNELS][DEPTH];
  logic        [PW-1:0]     wr_ptr_q [CHANNELS];
  logic        [PW:0]       cnt_q    [CHANNELS];
  logic signed [SUM_W-1:0]  sum_q    [CHANNELS];

  logic [2:0]               win_q, win_d;
  logic                     m_valid_q, m_valid_d;
  logic signed [DATA_W-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]          m_chan_q, m_chan_d;
  logic                     err_q, err_d;

  logic                     clr_s, acc_s, chan_ok_s, acc_ok_s, full_s;
  logic [CH_W-1:0]          ch_idx_s;
  logic [PW:0]              win_size_s;
  logic [PW-1:0]            rd_idx_s;
  logic signed [DATA_W-1:0] oldest_s;
  logic signed [SUM_W-1:0]  sum_nx_s;

  assign clr_s    = reset || flush;
  assign s_ready  = !clr_s && (!m_valid_q || m_ready);
  assign acc_s    = s_valid && s_ready;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_chan   = m_chan_q;
  assign err_chan = err_q;

  // Datapath for the addressed channel: evict the sample leaving the window once it is full.
  always_comb begin
    chan_ok_s  = ({1'b0, s_chan} < CH_LIM);
    acc_ok_s   = acc_s && chan_ok_s;
    ch_idx_s   = chan_ok_s ? s_chan : '0;
    win_size_s = (PW + 1)'(1) << win_q;
    rd_idx_s   = wr_ptr_q[ch_idx_s] - win_size_s[PW-1:0];
    full_s     = (cnt_q[ch_idx_s] == win_size_s);
    oldest_s   = full_s ? ring_q[ch_idx_s][rd_idx_s] : '0;
    sum_nx_s   = sum_q[ch_idx_s]
               + {{MAX_LOG2_DEPTH{s_data[DATA_W-1]}}, s_data}
               - {{MAX_LOG2_DEPTH{oldest_s[DATA_W-1]}}, oldest_s};
    win_d      = (win_log2 > WIN_MAX) ? WIN_MAX : win_log2;
  end

  // Output register and sticky error next-state.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    err_d     = err_q;
    if (acc_ok_s) begin
      m_valid_d = 1'b1;
      m_data_d  = DATA_W'(sum_nx_s >>> win_q);
      m_chan_d  = s_chan;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    if (acc_s && !chan_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control state; reset and flush share the clear path and both reload the window.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sum_q[i]    <= '0;
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
      end
      win_q     <= win_d;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      err_q     <= err_d;
      if (acc_ok_s) begin
        sum_q[ch_idx_s]    <= sum_nx_s;
        wr_ptr_q[ch_idx_s] <= wr_ptr_q[ch_idx_s] + PW'(1);
        cnt_q[ch_idx_s]    <= full_s ? cnt_q[ch_idx_s] : cnt_q[ch_idx_s] + (PW + 1)'(1);
      end
    end
  end

  // History storage is never cleared; the fill count hides stale entries.
  always_ff @(posedge clk) begin
    if (acc_ok_s) begin
      ring_q[ch_idx_s][wr_ptr_q[ch_idx_s]] <= s_data;
    end
  end

endmodule
